// File: rtl/chan_start_pkg.sv
// Purpose: shared types and bit positions for the channelizer start sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package chan_start_pkg;

    // Default width of the frame counter and of the frame-limit field
    localparam int NFRAME_W_DEF = 16;

    // Control word bit positions
    localparam int CTRL_ARM_BIT   = 0;
    localparam int CTRL_STOP_BIT  = 1;
    localparam int CTRL_LIMIT_LSB = 16;

    // Status word bit positions
    localparam int STAT_STATE_LSB = 0;
    localparam int STAT_ERR_BIT   = 2;
    localparam int STAT_CNT_LSB   = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_e;

    // Readback word layout, MSB first
    typedef struct packed {
        logic [15:0] frame_cnt;
        logic [12:0] rsvd;
        logic        sync_err;
        seq_state_e  state;
    } status_t;

endpackage

// File: rtl/sync_period_mon.sv
// Purpose: flags sync pulses that arrive early/late relative to SYNC_PERIOD (sticky).
// Latency: err rises the cycle after the offending sync or the missed-sync cycle.
// Backpressure: none; observes sync_in only.
module sync_period_mon #(
    parameter int SYNC_PERIOD = 256
) (
    input  logic user_clk,
    input  logic user_rst_n,
    input  logic sync_in,
    input  logic enable,
    input  logic clear,
    output logic err
);

    localparam int CNT_W = $clog2(SYNC_PERIOD + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SYNC_PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(SYNC_PERIOD);

    logic [CNT_W-1:0] cnt_q;
    logic             err_q;

    // Cycles since the last sync; saturates so a dead sync line cannot wrap into a false match
    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            cnt_q <= '0;
        end else if (sync_in) begin
            cnt_q <= '0;
        end else if (cnt_q != CNT_SAT) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Sticky error: wrong spacing on a sync, or the period elapsing with no sync
    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            err_q <= 1'b0;
        end else if (clear) begin
            err_q <= 1'b0;
        end else if (enable && ((sync_in && (cnt_q != CNT_LAST)) ||
                                (!sync_in && (cnt_q == CNT_LAST)))) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;

endmodule

// File: rtl/chan_start_sequencer.sv
// Purpose: arms on a software write, starts processing on the next frame sync, optional frame limit.
// Latency: start_pulse/run_en one cycle after the starting sync; status_out one cycle after state.
// Backpressure: none; sync_in and ctrl_in are sampled every cycle.
module chan_start_sequencer
    import chan_start_pkg::*;
#(
    parameter int SYNC_PERIOD = 256,
    parameter int NFRAME_W    = NFRAME_W_DEF
) (
    input  logic        user_clk,
    input  logic        user_rst_n,
    input  logic [31:0] ctrl_in,
    input  logic        sync_in,
    output logic        start_pulse,
    output logic        run_en,
    output logic [31:0] status_out
);

    logic [31:0]         ctrl_q;
    logic [31:0]         ctrl_q_d;
    logic                primed_q;
    seq_state_e          state_q;
    logic                start_pulse_q;
    logic                run_en_q;
    logic [NFRAME_W-1:0] frame_cnt_q;
    logic [NFRAME_W-1:0] limit_q;
    status_t             status_q;
    logic                sync_err;
    logic                arm_edge;
    logic                stop;
    logic                arm_accept;
    logic                ctrl_unused;

    assign arm_edge   = ctrl_q[CTRL_ARM_BIT] & ~ctrl_q_d[CTRL_ARM_BIT];
    assign stop       = ctrl_q[CTRL_STOP_BIT];
    // Only an arm edge seen in IDLE (and not overridden by stop) starts a new session
    assign arm_accept = arm_edge & ~stop & (state_q == ST_IDLE);

    assign ctrl_unused = ^{ctrl_q_d[31:1], ctrl_q[CTRL_LIMIT_LSB-1:CTRL_STOP_BIT+1]};

    // Capture the control word and a delayed copy; on the first edge after reset the copy
    // loads ctrl_in directly so an arm bit already high at release is not taken as an edge
    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            ctrl_q   <= '0;
            ctrl_q_d <= '0;
            primed_q <= 1'b0;
        end else begin
            ctrl_q   <= ctrl_in;
            ctrl_q_d <= primed_q ? ctrl_q : ctrl_in;
            primed_q <= 1'b1;
        end
    end

    // Sequencer FSM with registered start_pulse, run_en, frame counter and latched limit
    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            state_q       <= ST_IDLE;
            start_pulse_q <= 1'b0;
            run_en_q      <= 1'b0;
            frame_cnt_q   <= '0;
            limit_q       <= '0;
        end else begin
            start_pulse_q <= 1'b0;
            if (stop) begin
                state_q  <= ST_IDLE;
                run_en_q <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (arm_accept) begin
                            state_q <= ST_ARMED;
                            limit_q <= ctrl_q[CTRL_LIMIT_LSB +: NFRAME_W];
                        end
                    end
                    ST_ARMED: begin
                        if (sync_in) begin
                            state_q       <= ST_RUN;
                            start_pulse_q <= 1'b1;
                            run_en_q      <= 1'b1;
                            frame_cnt_q   <= '0;
                        end
                    end
                    ST_RUN: begin
                        if (sync_in) begin
                            if ((limit_q != '0) && (frame_cnt_q == limit_q - NFRAME_W'(1))) begin
                                state_q  <= ST_DONE;
                                run_en_q <= 1'b0;
                            end else begin
                                frame_cnt_q <= frame_cnt_q + NFRAME_W'(1);
                            end
                        end
                    end
                    ST_DONE: begin
                        if (!ctrl_q[CTRL_ARM_BIT]) begin
                            state_q <= ST_IDLE;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    sync_period_mon #(
        .SYNC_PERIOD(SYNC_PERIOD)
    ) u_sync_mon (
        .user_clk  (user_clk),
        .user_rst_n(user_rst_n),
        .sync_in   (sync_in),
        .enable    (state_q == ST_RUN),
        .clear     (arm_accept),
        .err       (sync_err)
    );

    // Readback word, one cycle behind the live state
    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            status_q <= '0;
        end else begin
            status_q.frame_cnt <= 16'(frame_cnt_q);
            status_q.rsvd      <= '0;
            status_q.sync_err  <= sync_err;
            status_q.state     <= state_q;
        end
    end

    assign start_pulse = start_pulse_q;
    assign run_en      = run_en_q;
    assign status_out  = status_q;

endmodule

// File: tb/tb_chan_start_sequencer.sv
// Purpose: directed self-checking bench for chan_start_sequencer.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_chan_start_sequencer;
    import chan_start_pkg::*;

    localparam int SP = 256;

    logic        user_clk = 1'b0;
    logic        user_rst_n;
    logic [31:0] ctrl_in;
    logic        sync_in;
    logic        start_pulse;
    logic        run_en;
    logic [31:0] status_out;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int a;
    int t;

    chan_start_sequencer #(
        .SYNC_PERIOD(SP),
        .NFRAME_W   (16)
    ) dut (
        .user_clk   (user_clk),
        .user_rst_n (user_rst_n),
        .ctrl_in    (ctrl_in),
        .sync_in    (sync_in),
        .start_pulse(start_pulse),
        .run_en     (run_en),
        .status_out (status_out)
    );

    always #5 user_clk = ~user_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge user_clk);
        #1;
        cyc++;
    endtask

    // Pulse sync_in during cycle tc; returns in cycle tc+1
    task automatic sync_at(input int tc);
        while (cyc < tc) step();
        sync_in = 1'b1;
        step();
        sync_in = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with arm already high
        user_rst_n = 1'b0;
        ctrl_in    = 32'h0000_0001;
        sync_in    = 1'b0;
        #3;
        check("rst_status", status_out, 32'h0);
        check("rst_run_en", 32'(run_en), 32'h0);
        check("rst_start", 32'(start_pulse), 32'h0);
        repeat (3) step();
        user_rst_n = 1'b1;
        repeat (6) step();
        check("noarm_state", 32'(status_out[1:0]), 32'(ST_IDLE));
        sync_at(cyc + 2);
        check("noarm_start", 32'(start_pulse), 32'h0);
        step();
        check("noarm_sync_state", 32'(status_out[1:0]), 32'(ST_IDLE));
        check("noarm_run_en", 32'(run_en), 32'h0);
        ctrl_in = 32'h0;
        repeat (4) step();

        // Arm, sync 100 cycles after the write
        a = cyc;
        ctrl_in = 32'h0000_0001;
        sync_at(a + 100);
        check("start_t1", 32'(start_pulse), 32'h1);
        check("run_en_t1", 32'(run_en), 32'h1);
        step();
        check("start_t2", 32'(start_pulse), 32'h0);
        check("run_en_t2", 32'(run_en), 32'h1);
        check("state_run", 32'(status_out[1:0]), 32'(ST_RUN));
        check("cnt_first", 32'(status_out[31:16]), 32'h0);
        check("err_first", 32'(status_out[2]), 32'h0);
        sync_at(a + 100 + SP);
        step();
        check("cnt_second", 32'(status_out[31:16]), 32'h1);
        check("err_second", 32'(status_out[2]), 32'h0);

        // Stop mid-run
        a = cyc;
        ctrl_in = 32'h0000_0003;
        repeat (3) step();
        check("stop_state", 32'(status_out[1:0]), 32'(ST_IDLE));
        check("stop_run_en", 32'(run_en), 32'h0);
        sync_at(a + SP);
        check("stop_sync_start", 32'(start_pulse), 32'h0);
        check("stop_sync_run_en", 32'(run_en), 32'h0);
        step();
        check("stop_sync_state", 32'(status_out[1:0]), 32'(ST_IDLE));
        ctrl_in = 32'h0;
        repeat (3) step();

        // Limit 3, limit field rewritten after arming must not matter
        a = cyc;
        ctrl_in = 32'h0003_0001;
        repeat (5) step();
        ctrl_in = 32'h0005_0001;
        t = a + 10;
        sync_at(t);
        step();
        check("lim_state_run", 32'(status_out[1:0]), 32'(ST_RUN));
        check("lim_cnt0", 32'(status_out[31:16]), 32'h0);
        sync_at(t + SP);
        step();
        check("lim_cnt1", 32'(status_out[31:16]), 32'h1);
        sync_at(t + 2 * SP);
        step();
        check("lim_cnt2", 32'(status_out[31:16]), 32'h2);
        check("lim_run_en_on", 32'(run_en), 32'h1);
        sync_at(t + 3 * SP);
        check("lim_run_en_off", 32'(run_en), 32'h0);
        step();
        check("lim_state_done", 32'(status_out[1:0]), 32'(ST_DONE));
        check("lim_cnt_hold", 32'(status_out[31:16]), 32'h2);
        check("lim_err", 32'(status_out[2]), 32'h0);
        sync_at(t + 4 * SP);
        step();
        check("lim_done_stays", 32'(status_out[1:0]), 32'(ST_DONE));
        check("lim_cnt_stays", 32'(status_out[31:16]), 32'h2);
        ctrl_in = 32'h0;
        repeat (3) step();
        check("done_to_idle", 32'(status_out[1:0]), 32'(ST_IDLE));

        // Short sync period sets sticky error; next arm clears it
        a = cyc;
        ctrl_in = 32'h0000_0001;
        t = a + 4;
        sync_at(t);
        sync_at(t + SP);
        step();
        check("err_clean", 32'(status_out[2]), 32'h0);
        sync_at(t + SP + 200);
        step();
        check("err_set", 32'(status_out[2]), 32'h1);
        sync_at(t + 2 * SP + 200);
        step();
        check("err_sticky", 32'(status_out[2]), 32'h1);
        check("err_run_en", 32'(run_en), 32'h1);
        check("err_state", 32'(status_out[1:0]), 32'(ST_RUN));
        ctrl_in = 32'h0000_0002;
        repeat (3) step();
        ctrl_in = 32'h0;
        repeat (3) step();
        check("err_after_stop", 32'(status_out[2]), 32'h1);
        ctrl_in = 32'h0000_0001;
        repeat (4) step();
        check("err_cleared", 32'(status_out[2]), 32'h0);
        check("rearm_state", 32'(status_out[1:0]), 32'(ST_ARMED));
        ctrl_in = 32'h0000_0002;
        repeat (3) step();
        ctrl_in = 32'h0;
        repeat (3) step();

        // Arm edge coincident with sync: start follows the next sync
        a = cyc;
        ctrl_in = 32'h0000_0001;
        sync_at(a + 1);
        check("coinc_no_start", 32'(start_pulse), 32'h0);
        step();
        check("coinc_armed", 32'(status_out[1:0]), 32'(ST_ARMED));
        check("coinc_run_en", 32'(run_en), 32'h0);
        sync_at(a + 1 + SP);
        check("coinc_start2", 32'(start_pulse), 32'h1);

        // Continuous run through counter wrap
        sync_in = 1'b1;
        repeat (65535) step();
        sync_in = 1'b0;
        step();
        check("wrap_ffff", 32'(status_out[31:16]), 32'h0000_FFFF);
        sync_at(cyc + 3);
        step();
        check("wrap_zero", 32'(status_out[31:16]), 32'h0);
        check("wrap_run_en0", 32'(run_en), 32'h1);
        sync_at(cyc + 3);
        step();
        check("wrap_one", 32'(status_out[31:16]), 32'h1);
        check("wrap_run_en1", 32'(run_en), 32'h1);
        check("wrap_state", 32'(status_out[1:0]), 32'(ST_RUN));

        // Asynchronous reset mid-run
        #2;
        user_rst_n = 1'b0;
        #1;
        check("arst_run_en", 32'(run_en), 32'h0);
        check("arst_status", status_out, 32'h0);
        check("arst_start", 32'(start_pulse), 32'h0);
        #2;
        user_rst_n = 1'b1;
        repeat (3) step();
        check("post_rst_status", status_out, 32'h0);
        check("post_rst_run_en", 32'(run_en), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
